// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: LEGv8 instruction fetch stage.
// Owns the PC, fetches 32-bit words over a req/ack handshake and presents
// them on Inst until the control unit selects the next PC.
// Optional macro FETCH_MISALIGN_TRAP_EN: trap a misaligned next PC in the
// FAULT state instead of silently clearing PC[1:0].
module inst_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INST = 32'hD503201F
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [1:0]         PC_SEL,
   input  logic               PC_MUX,
   input  logic signed [63:0] K,
   input  logic [63:0]        A_bus,
   output logic [63:0]        mem_addr,
   output logic               mem_req,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   output logic [31:0]        Inst,
   output logic               inst_valid,
   output logic [63:0]        PC,
   output logic [31:0]        inst_count,
   output logic               fetch_fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_EXEC  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_count_q, inst_count_d;

   logic [63:0] raw_pc;
   logic [63:0] target_pc;
   logic        misaligned;
   logic        capture;
   logic        retire;

   // Raw next-PC selection; all arithmetic wraps modulo 2^64.
   function automatic logic [63:0] calc_next_pc(
      input logic [1:0]         sel,
      input logic               mux,
      input logic [63:0]        pc,
      input logic signed [63:0] k,
      input logic [63:0]        a
   );
      logic [63:0] nxt;
      case (sel)
         2'b01:   nxt = pc + 64'd4;
         2'b10:   nxt = mux ? (pc + 64'(k <<< 2)) : a;
         default: nxt = a;
      endcase
      return nxt;
   endfunction

   assign capture = (state_q == S_REQ) && mem_ack;
   assign retire  = (state_q == S_EXEC) && (PC_SEL != 2'b00);
   assign raw_pc  = calc_next_pc(PC_SEL, PC_MUX, pc_q, K, A_bus);

`ifdef FETCH_MISALIGN_TRAP_EN
   // Keep the offending target so software can inspect it after the trap.
   assign target_pc  = raw_pc;
   assign misaligned = (raw_pc[1:0] != 2'b00);
`else
   // Word alignment is enforced by clearing the low address bits.
   assign target_pc  = raw_pc & ~64'h3;
   assign misaligned = 1'b0;
`endif

   // State register; reset always returns to IDLE so a stale ack is dropped.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   if (mem_ack) state_d = S_EXEC;
         S_EXEC:  if (PC_SEL != 2'b00) state_d = misaligned ? S_FAULT : S_REQ;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request only in REQ, fault flag only in FAULT.
   always_comb begin
      mem_req     = (state_q == S_REQ);
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault = (state_q == S_FAULT);
`else
      fetch_fault = 1'b0;
`endif
   end

   // Datapath next values: capture on ack, advance PC and clear Inst on retire.
   always_comb begin
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      inst_count_d = inst_count_q;
      if (capture) begin
         inst_d       = mem_rdata;
         inst_valid_d = 1'b1;
      end else if (retire) begin
         pc_d         = target_pc;
         inst_d       = NOP_INST;
         inst_valid_d = 1'b0;
         inst_count_d = inst_count_q + 32'd1;
      end
   end

   // Datapath registers, all cleared asynchronously by Reset.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc_q         <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_valid_q <= 1'b0;
         inst_count_q <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         inst_count_q <= inst_count_d;
      end
   end

   assign mem_addr   = pc_q;
   assign PC         = pc_q;
   assign Inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign inst_count = inst_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed and randomized fetch/retire
// sequence checked against a PC/count reference model.
module tb_inst_fetch_unit;

   localparam logic [31:0] NOP = 32'hD503201F;

   logic               CLK = 1'b0;
   logic               Reset = 1'b0;
   logic [1:0]         PC_SEL = 2'b00;
   logic               PC_MUX = 1'b0;
   logic signed [63:0] K = '0;
   logic [63:0]        A_bus = '0;
   logic [63:0]        mem_addr;
   logic               mem_req;
   logic               mem_ack = 1'b0;
   logic [31:0]        mem_rdata = '0;
   logic [31:0]        Inst;
   logic               inst_valid;
   logic [63:0]        PC;
   logic [31:0]        inst_count;
   logic               fetch_fault;

   int unsigned npass  = 0;
   int unsigned ntotal = 0;

   // Reference model state
   logic [63:0] exp_pc  = 64'h0;
   logic [31:0] exp_cnt = 32'h0;
   logic [31:0] exp_inst = NOP;
   bit          exp_fault = 1'b0;

   inst_fetch_unit dut (
      .CLK(CLK), .Reset(Reset), .PC_SEL(PC_SEL), .PC_MUX(PC_MUX), .K(K),
      .A_bus(A_bus), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .Inst(Inst), .inst_valid(inst_valid), .PC(PC),
      .inst_count(inst_count), .fetch_fault(fetch_fault)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},    PC, 64'h0);
      chk({tag, "_addr"},  mem_addr, 64'h0);
      chk({tag, "_req"},   64'(mem_req), 64'h0);
      chk({tag, "_vld"},   64'(inst_valid), 64'h0);
      chk({tag, "_inst"},  64'(Inst), 64'(NOP));
      chk({tag, "_cnt"},   64'(inst_count), 64'h0);
      chk({tag, "_fault"}, 64'(fetch_fault), 64'h0);
   endtask

   // Called at a negedge while the DUT is in REQ; waits w cycles, then acks.
   task automatic fetch(input int w, input logic [31:0] data);
      for (int i = 0; i < w; i++) begin
         mem_ack = 1'b0;
         chk("wait_req",  64'(mem_req), 64'h1);
         chk("wait_addr", mem_addr, exp_pc);
         @(negedge CLK);
      end
      chk("req",      64'(mem_req), 64'h1);
      chk("req_addr", mem_addr, exp_pc);
      chk("req_vld",  64'(inst_valid), 64'h0);
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge CLK);
      mem_ack   = 1'b0;
      exp_inst  = data;
      chk("got_vld",   64'(inst_valid), 64'h1);
      chk("got_inst",  64'(Inst), 64'(exp_inst));
      chk("got_pc",    PC, exp_pc);
      chk("req_drop",  64'(mem_req), 64'h0);
      chk("got_fault", 64'(fetch_fault), 64'h0);
   endtask

   // Called at a negedge while in EXEC: hold for `holds` cycles, then retire.
   task automatic retire(input logic [1:0] sel, input logic mux,
                         input logic [63:0] k, input logic [63:0] a, input int holds);
      logic [63:0] nxt;
      for (int h = 0; h < holds; h++) begin
         PC_SEL = 2'b00;
         @(negedge CLK);
         chk("hold_vld",  64'(inst_valid), 64'h1);
         chk("hold_inst", 64'(Inst), 64'(exp_inst));
         chk("hold_pc",   PC, exp_pc);
         chk("hold_req",  64'(mem_req), 64'h0);
      end
      PC_SEL = sel; PC_MUX = mux; K = k; A_bus = a;
      @(negedge CLK);
      PC_SEL = 2'b00;
      if (sel == 2'b01)                nxt = exp_pc + 64'd4;
      else if (sel == 2'b10 && mux)    nxt = exp_pc + k * 64'd4;
      else                             nxt = a;
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_fault = (nxt % 4) != 0;
`else
      nxt = nxt - (nxt % 4);
`endif
      exp_pc  = nxt;
      exp_cnt = exp_cnt + 32'd1;
      chk("ret_cnt",  64'(inst_count), 64'(exp_cnt));
      chk("ret_vld",  64'(inst_valid), 64'h0);
      chk("ret_inst", 64'(Inst), 64'(NOP));
      chk("ret_pc",   PC, exp_pc);
      chk("ret_req",  64'(mem_req), exp_fault ? 64'h0 : 64'h1);
      if (!exp_fault) chk("ret_addr", mem_addr, exp_pc);
      chk("ret_fault", 64'(fetch_fault), 64'(exp_fault));
   endtask

   // Release reset at a negedge with a stale ack present during IDLE.
   task automatic release_with_stale_ack();
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      Reset     = 1'b0;
      exp_pc = 64'h0; exp_cnt = 32'h0; exp_inst = NOP; exp_fault = 1'b0;
      @(negedge CLK);
      chk("idle_ack_vld",  64'(inst_valid), 64'h0);
      chk("idle_ack_inst", 64'(Inst), 64'(NOP));
      chk("idle_req_now",  64'(mem_req), 64'h1);
   endtask

   initial begin
      #1 Reset = 1'b1;
      @(negedge CLK);
      chk_reset_state("rst");
      @(negedge CLK);
      release_with_stale_ack();

      // Sequential fetch: 0, 4, 8, count reaches 3
      for (int i = 0; i < 3; i++) begin
         fetch(0, 32'h91000421);
         retire(2'b01, 1'b0, 64'h0, 64'h0, 0);
      end
      chk("seq_count3", 64'(inst_count), 64'd3);
      chk("seq_addr12", mem_addr, 64'd12);

      // Wait states, then multi-cycle hold
      fetch(3, 32'h8B020020);
      retire(2'b01, 1'b0, 64'h0, 64'h0, 2);

      // Branches
      fetch(0, 32'h11111111);
      retire(2'b11, 1'b0, 64'h0, 64'h40, 0);
      fetch(1, 32'h22222222);
      retire(2'b10, 1'b1, -64'sd4, 64'h0, 0);
      chk("br_k_neg", mem_addr, 64'h30);
      fetch(0, 32'h33333333);
      retire(2'b10, 1'b0, 64'h0, 64'h1234, 0);
      fetch(0, 32'h34343434);
      retire(2'b11, 1'b0, 64'h0, 64'h200, 0);
      chk("br_reg", mem_addr, 64'h200);

      // PC and count wrap
      fetch(0, 32'h44444444);
      retire(2'b11, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      fetch(0, 32'h55555555);
      force dut.inst_count_q = 32'hFFFF_FFFF;
      #1 release dut.inst_count_q;
      exp_cnt = 32'hFFFF_FFFF;
      retire(2'b01, 1'b0, 64'h0, 64'h0, 0);
      chk("wrap_addr", mem_addr, 64'h0);
      chk("wrap_cnt",  64'(inst_count), 64'h0);

      // Randomized instruction stream with aligned targets
      for (int n = 0; n < 16; n++) begin
         int          ki;
         logic [1:0]  sel;
         logic [63:0] a;
         ki  = int'($urandom_range(0, 64)) - 32;
         sel = 2'($urandom_range(1, 3));
         a   = {$urandom, $urandom} & ~64'h3;
         fetch(int'($urandom_range(0, 2)), $urandom);
         retire(sel, 1'($urandom), {{32{ki[31]}}, ki}, a, int'($urandom_range(0, 2)));
      end

      // Mid-operation reset with an ack pending
      mem_ack = 1'b0;
      @(negedge CLK);
      chk("pend_req", 64'(mem_req), 64'h1);
      Reset = 1'b1;
      #1;
      chk_reset_state("midrst");
      @(negedge CLK);
      release_with_stale_ack();
      fetch(0, 32'h66666666);
      chk("midrst_pc0", PC, 64'h0);

      // Misaligned register target
      retire(2'b11, 1'b0, 64'h0, 64'h102, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_fault", 64'(fetch_fault), 64'h1);
      chk("mis_pc",    PC, 64'h102);
      mem_ack = 1'b1;
      PC_SEL  = 2'b01;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("mis_stay_fault", 64'(fetch_fault), 64'h1);
         chk("mis_stay_req",   64'(mem_req), 64'h0);
         chk("mis_stay_vld",   64'(inst_valid), 64'h0);
         chk("mis_stay_pc",    PC, 64'h102);
      end
      mem_ack = 1'b0;
      PC_SEL  = 2'b00;
`else
      chk("mis_addr",  mem_addr, 64'h100);
      chk("mis_fault", 64'(fetch_fault), 64'h0);
      fetch(0, 32'h77777777);
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
